segment_scan_controller: RTL
============================

Name: segment_scan_controller

Overview:
Time-multiplexing scheduler that shares one physical 8-bit segment bus between four digit drivers (display0..display3, bit 7 = dp, bits 6:0 = segments a..g, 1 = lit).
- Grants the bus round-robin to enabled digits.
- Inserts a blanking gap between digits to suppress ghosting.
- Sits between the per-digit segment drivers and the board pins.

Parameters:
SLOT_CYCLES, 1000, clk cycles each digit is driven (>=1)
BLANK_CYCLES, 16, clk cycles all digits are off between slots (>=1)
SEG_ACTIVE_LOW, 1, 1 = seg output inverted (lit = 0)
DIG_ACTIVE_LOW, 1, 1 = digit_en output inverted (selected = 0)

Ports:
clk  in  1  system clock
sync_reset  in  1  synchronous, active-high reset
display0  in  8  digit 0 pattern {dp, g..a}, 1 = lit
display1  in  8  digit 1 pattern
display2  in  8  digit 2 pattern
display3  in  8  digit 3 pattern
digit_mask  in  4  1 = digit participates in scan
seg  out  8  shared segment bus, polarity per SEG_ACTIVE_LOW
digit_en  out  4  one-hot digit select, polarity per DIG_ACTIVE_LOW
frame_start  out  1  one-cycle pulse on first DRIVE cycle of digit 0

Behaviour:
- Reset is synchronous and active-high on clk, single clock domain. When sync_reset is sampled high:
  - state = BLANK, cnt = 0, cur_idx = 3.
  - seg and digit_en at inactive level (all 0 logical); frame_start = 0.
- "Off" means seg logical 0x00 and digit_en logical 0000, after polarity inversion.
- All outputs are registered. Outputs reflect the current state in the same cycle the state register holds it.
- States:
  - BLANK: outputs off; cnt counts 0..BLANK_CYCLES-1. On the last cycle, pick the next digit:
    - digit_mask == 0 -> IDLE.
    - otherwise -> DRIVE. Search order is cur_idx+1, +2, +3, +4 (mod 4), taking the first with its mask bit set. Load cur_idx, latch that digit's displayN into snap_reg, cnt = 0.
  - DRIVE: seg = snap_reg (polarity applied); digit_en = onehot(cur_idx). cnt counts 0..SLOT_CYCLES-1. On the last cycle -> BLANK, cnt = 0.
  - IDLE: outputs off. Any cycle with digit_mask != 0 -> BLANK, cnt = 0.
- Snapshot rule: displayN changes during DRIVE do not appear until that digit's next slot (no tearing).
- Mask sampling: only at the BLANK->DRIVE decision and in IDLE. Clearing the active digit's mask bit mid-DRIVE does not shorten the slot.
- Single enabled digit: that digit repeats DRIVE/BLANK.
- Fairness: an enabled digit waits at most 3 slots plus 4 blanks.
- First DRIVE after reset: BLANK_CYCLES cycles after reset deasserts. Digit is the lowest enabled index.
- frame_start = 1 exactly on the first DRIVE cycle where cur_idx = 0. Never pulses if digit 0 is masked.
- Counter width: $clog2(max(SLOT_CYCLES, BLANK_CYCLES)+1). No overflow; compare against N-1.
- sync_reset mid-DRIVE: next cycle outputs are off and the scan restarts as after reset.

Optional Feature:
Macro SEGMENT_SCAN_BRIGHTNESS_EN.
- Defined:
  - Adds input brightness [3:0], sampled at BLANK->DRIVE.
  - In DRIVE, seg is driven only while cnt < ((brightness+1)*SLOT_CYCLES)>>4; seg is off for the rest of the slot.
  - digit_en stays asserted for the full slot.
  - brightness = 15 gives full duty. Minimum is 1/16; a computed threshold of 0 is forced to 1.
- Undefined: no port; seg driven for the whole slot.

Decomposition:
Package segment_scan_pkg contains:
- state enum {IDLE, BLANK, DRIVE}.
- DIGITS = 4 constant.
- function rr_next(cur_idx, mask) returning the index, plus a valid flag for mask != 0.
- function apply_pol(value, active_low).

One sub-module, segment_scan_rr_pick: combinational round-robin selector. It is reusable by other shared-bus schedulers and is unit-testable alone.

Test Plan:
All scenarios use SLOT_CYCLES = 4, BLANK_CYCLES = 2, both polarity params = 0.
- Reset, mask = 1111, display0..3 = 0x01/0x02/0x04/0x08 -> cycles 0-1 off; cycles 2-5 digit_en = 0001 seg = 0x01 with frame_start at cycle 2; cycles 6-7 off; cycles 8-11 digit_en = 0010 seg = 0x02; the order repeats 0,1,2,3,0.
- mask = 1010 -> the scan alternates digit 1 and digit 3 only; frame_start never pulses.
- display2 changes 0x04 -> 0x7F during digit 2's slot -> seg stays 0x04 for that slot; the next digit 2 slot shows 0x7F.
- mask -> 0000 mid-DRIVE -> the slot completes, then BLANK, then IDLE with outputs off; mask -> 0100 -> 2 BLANK cycles, then digit 2 is driven.
- sync_reset asserted during DRIVE of digit 1 -> next cycle outputs off; after release, the first slot is digit 0.
- With SEGMENT_SCAN_BRIGHTNESS_EN, SLOT_CYCLES = 16, brightness = 3 -> seg lit for cnt 0-3, off for cnt 4-15; digit_en held for all 16 cycles.

Source files
------------

// File: rtl/segment_scan_pkg.sv
// Shared types and helpers for the segment bus scan scheduler.
// Optional feature macro used by the controller: SEGMENT_SCAN_BRIGHTNESS_EN.
package segment_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  localparam int DIGITS = 4;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } rr_pick_t;

  // Walk offsets high to low so the nearest enabled digit after cur_idx wins;
  // offset +4 wraps back to cur_idx itself.
  function automatic rr_pick_t rr_next(input logic [1:0] cur_idx,
                                       input logic [DIGITS-1:0] mask);
    rr_pick_t   r;
    logic [1:0] cand;
    r.valid = |mask;
    r.idx   = cur_idx;
    for (int k = DIGITS; k >= 1; k--) begin
      cand = cur_idx + 2'(k);
      if (mask[cand]) r.idx = cand;
    end
    return r;
  endfunction

  function automatic logic [7:0] apply_pol(input logic [7:0] value,
                                           input logic       active_low);
    return active_low ? ~value : value;
  endfunction

endpackage

// File: rtl/segment_scan_rr_pick.sv
// Combinational round-robin selector: next enabled index after cur_idx_i.
module segment_scan_rr_pick
  import segment_scan_pkg::*;
(
  input  logic [1:0]        cur_idx_i,
  input  logic [DIGITS-1:0] mask_i,
  output logic              valid_o,
  output logic [1:0]        idx_o
);

  rr_pick_t pick;

  always_comb begin
    pick    = rr_next(cur_idx_i, mask_i);
    valid_o = pick.valid;
    idx_o   = pick.idx;
  end

endmodule

// File: rtl/segment_scan_controller.sv
// Time-multiplexed 4-digit segment bus scheduler with inter-slot blanking.
// Optional macro SEGMENT_SCAN_BRIGHTNESS_EN adds a 4-bit per-slot duty control input.
module segment_scan_controller
  import segment_scan_pkg::*;
#(
  parameter int SLOT_CYCLES    = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       sync_reset,
  input  logic [7:0] display0,
  input  logic [7:0] display1,
  input  logic [7:0] display2,
  input  logic [7:0] display3,
  input  logic [3:0] digit_mask,
`ifdef SEGMENT_SCAN_BRIGHTNESS_EN
  input  logic [3:0] brightness,
`endif
  output logic [7:0] seg,
  output logic [3:0] digit_en,
  output logic       frame_start
);

  localparam int CNT_MAX = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [7:0]    SEG_OFF    = {8{SEG_ACTIVE_LOW}};
  localparam logic [3:0]    DEN_OFF    = {4{DIG_ACTIVE_LOW}};

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    snap_q, snap_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    den_q, den_d;
  logic          fs_q, fs_d;

  logic          pick_vld;
  logic [1:0]    pick_idx;
  logic [7:0]    disp [DIGITS];
  logic          seg_lit;
  logic [7:0]    seg_log;
  logic [3:0]    den_log;
  logic [7:0]    den_pol;

`ifdef SEGMENT_SCAN_BRIGHTNESS_EN
  logic [CW-1:0] thr_q, thr_d;

  // Lit portion of a slot; never below one cycle.
  function automatic logic [CW-1:0] lit_threshold(input logic [3:0] b);
    int t;
    t = ((int'(b) + 1) * SLOT_CYCLES) >>> 4;
    if (t < 1) t = 1;
    return CW'(t);
  endfunction
`endif

  assign disp[0] = display0;
  assign disp[1] = display1;
  assign disp[2] = display2;
  assign disp[3] = display3;

  segment_scan_rr_pick u_rr_pick (
    .cur_idx_i (idx_q),
    .mask_i    (digit_mask),
    .valid_o   (pick_vld),
    .idx_o     (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
`ifdef SEGMENT_SCAN_BRIGHTNESS_EN
    thr_d   = thr_q;
`endif
    unique case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d = '0;
          if (pick_vld) begin
            state_d = DRIVE;
            idx_d   = pick_idx;
            snap_d  = disp[pick_idx];
`ifdef SEGMENT_SCAN_BRIGHTNESS_EN
            thr_d   = lit_threshold(brightness);
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_q == SLOT_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (|digit_mask) begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase

    // Outputs are derived from the next state so the registered pins line up with the state register.
    seg_lit = (state_d == DRIVE);
`ifdef SEGMENT_SCAN_BRIGHTNESS_EN
    seg_lit = seg_lit && (cnt_d < thr_d);
`endif
    seg_log = seg_lit ? snap_d : 8'h00;
    den_log = (state_d == DRIVE) ? (4'b0001 << idx_d) : 4'b0000;
    seg_d   = apply_pol(seg_log, SEG_ACTIVE_LOW);
    den_pol = apply_pol({4'b0000, den_log}, DIG_ACTIVE_LOW);
    den_d   = den_pol[3:0];
    fs_d    = (state_d == DRIVE) && (state_q != DRIVE) && (idx_d == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd3;
      seg_q   <= SEG_OFF;
      den_q   <= DEN_OFF;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      den_q   <= den_d;
      fs_q    <= fs_d;
    end
  end

  always_ff @(posedge clk) begin
    snap_q <= snap_d;
`ifdef SEGMENT_SCAN_BRIGHTNESS_EN
    thr_q  <= thr_d;
`endif
  end

  assign seg         = seg_q;
  assign digit_en    = den_q;
  assign frame_start = fs_q;

endmodule
